mu0_datapath_hs: RTL and testbench

//  Parametrised MU0 datapath: PC, IR, ACC, ALU, X/Y/A muxes and a memory data register (MDR).

---
 rtl/mu0_datapath_hs.sv | 166 ++++++++++++++++
 tb/tb_mu0_datapath_hs.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mu0_datapath_hs.sv
// MU0 datapath (PC/IR/ACC/MDR, ALU, X/Y/A muxes, Z/N flags) with a req/ack memory bus engine.
// Define MU0_DP_TIMEOUT_EN to abort a REQ cycle that sees no ack within TIMEOUT cycles (bus_err).
module mu0_datapath_hs #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        M,
  input  logic              Xsel,
  input  logic              Ysel,
  input  logic              Asel,
  input  logic              PCen,
  input  logic              IRen,
  input  logic              ACCen,
  input  logic              mem_start,
  input  logic              mem_wr,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] mdr,
  output logic              flag_z,
  output logic              flag_n,
  output logic              bus_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  if ((ADDR_W > DATA_W) || (DATA_W < 8) || (TIMEOUT < 1)) begin : g_param_check
    $error("mu0_datapath_hs: invalid DATA_W/ADDR_W/TIMEOUT");
  end

  // Wrapping ALU: no carry out, X+1 at all-ones rolls to zero.
  function automatic logic [DATA_W-1:0] alu_op(input logic [1:0] m,
                                               input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y);
    case (m)
      2'b00:   alu_op = y;
      2'b01:   alu_op = x + y;
      2'b10:   alu_op = x + ONE;
      default: alu_op = x - y;
    endcase
  endfunction

  logic [1:0]        state;
  logic [DATA_W-1:0] alu_x;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] alu_z;
  logic              tmo_abort;

  assign alu_x = Xsel ? acc : pc;
  assign alu_y = Ysel ? mdr : ir;
  assign alu_z = alu_op(M, alu_x, alu_y);

  // Architectural registers load on their enables regardless of bus activity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= '0;
      ir     <= '0;
      acc    <= '0;
      flag_z <= 1'b1;
      flag_n <= 1'b0;
    end else begin
      if (PCen) pc <= alu_z;
      if (IRen) ir <= mdr;
      if (ACCen) begin
        acc    <= alu_z;
        flag_z <= (alu_z == '0);
        flag_n <= alu_z[DATA_W-1];
      end
    end
  end

  // Only a read that is acknowledged during REQ updates mdr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdr <= '0;
    end else if ((state == ST_REQ) && mem_ack && !mem_we) begin
      mdr <= mem_rdata;
    end
  end

  // Bus engine: address, data and direction are captured at start and held for the whole REQ phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_start) begin
            state     <= ST_REQ;
            mem_req   <= 1'b1;
            mem_we    <= mem_wr;
            mem_addr  <= Asel ? ir[ADDR_W-1:0] : pc[ADDR_W-1:0];
            mem_wdata <= acc;
          end
        end
        ST_REQ: begin
          if (mem_ack || tmo_abort) begin
            state   <= ST_DONE;
            mem_req <= 1'b0;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_busy = (state != ST_IDLE);
  assign mem_done = (state == ST_DONE);

`ifdef MU0_DP_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] req_cnt;
  logic             err_q;

  // Ack is checked first in the FSM, so an ack on the limit cycle completes normally.
  assign tmo_abort = (state == ST_REQ) && (req_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_cnt <= '0;
    end else if (state != ST_REQ) begin
      req_cnt <= '0;
    end else begin
      req_cnt <= req_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (tmo_abort && !mem_ack) begin
      err_q <= 1'b1;
    end else if (state == ST_DONE) begin
      err_q <= 1'b0;
    end
  end

  assign bus_err = mem_done && err_q;
`else
  assign tmo_abort = 1'b0;
  assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mu0_datapath_hs.sv
// Self-checking bench for mu0_datapath_hs: directed scenarios plus randomized cycles
// compared against a transaction-level reference model of registers and bus.
module tb_mu0_datapath_hs;
  localparam int DW  = 16;
  localparam int AW  = 12;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    M;
  logic          Xsel, Ysel, Asel, PCen, IRen, ACCen;
  logic          mem_start, mem_wr;
  logic          mem_busy, mem_done, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack;
  logic [DW-1:0] acc, ir, pc, mdr;
  logic          flag_z, flag_n, bus_err;

  always #5 clk = ~clk;

  mu0_datapath_hs #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .M(M), .Xsel(Xsel), .Ysel(Ysel), .Asel(Asel),
    .PCen(PCen), .IRen(IRen), .ACCen(ACCen), .mem_start(mem_start), .mem_wr(mem_wr),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .acc(acc), .ir(ir), .pc(pc), .mdr(mdr), .flag_z(flag_z), .flag_n(flag_n),
    .bus_err(bus_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: architectural state plus the outstanding bus transaction.
  logic [DW-1:0] m_pc, m_ir, m_acc, m_mdr;
  logic          m_z, m_n;
  int            m_phase;  // 0 none, 1 waiting for ack, 2 completion cycle
  int            m_cnt;
  logic          m_err, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  task automatic model_reset();
    m_pc = '0; m_ir = '0; m_acc = '0; m_mdr = '0; m_z = 1'b1; m_n = 1'b0;
    m_phase = 0; m_cnt = 0; m_err = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
  endtask

  task automatic idle_inputs();
    M = 2'b00; Xsel = 0; Ysel = 0; Asel = 0; PCen = 0; IRen = 0; ACCen = 0;
    mem_start = 0; mem_wr = 0; mem_ack = 0; mem_rdata = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven, then clock the DUT.
  task automatic step();
    logic [DW-1:0] o_pc, o_ir, o_acc, o_mdr, x, y, z;
    o_pc = m_pc; o_ir = m_ir; o_acc = m_acc; o_mdr = m_mdr;
    x = Xsel ? o_acc : o_pc;
    y = Ysel ? o_mdr : o_ir;
    case (M)
      2'b00:   z = y;
      2'b01:   z = DW'(int'(x) + int'(y));
      2'b10:   z = DW'(int'(x) + 1);
      default: z = DW'(int'(x) - int'(y));
    endcase
    if (PCen) m_pc = z;
    if (IRen) m_ir = o_mdr;
    if (ACCen) begin m_acc = z; m_z = (z == 0); m_n = z[DW-1]; end
    case (m_phase)
      0: if (mem_start) begin
           m_phase = 1; m_cnt = 0; m_err = 1'b0; m_we = mem_wr;
           m_addr = Asel ? o_ir[AW-1:0] : o_pc[AW-1:0];
           m_wdata = o_acc;
         end
      1: if (mem_ack) begin
           if (!m_we) m_mdr = mem_rdata;
           m_phase = 2;
         end else begin
           m_cnt++;
`ifdef MU0_DP_TIMEOUT_EN
           if (m_cnt == TMO) begin m_phase = 2; m_err = 1'b1; end
`endif
         end
      default: begin m_phase = 0; m_err = 1'b0; end
    endcase
    @(posedge clk); #1;
  endtask

  task automatic inc_pc(input int n);
    Xsel = 0; M = 2'b10; PCen = 1;
    repeat (n) step();
    PCen = 0;
  endtask

  task automatic bus_read(input logic [DW-1:0] d, input int waits);
    mem_wr = 0; mem_start = 1; step(); mem_start = 0;
    repeat (waits) step();
    mem_ack = 1; mem_rdata = d; step();
    mem_ack = 0; step();
  endtask

  task automatic acc_from_mdr();
    Ysel = 1; M = 2'b00; ACCen = 1; step(); ACCen = 0; Ysel = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs(); model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({pc, ir, acc, mdr} !== 64'h0) begin bad++; $display("FAIL reset_regs got=%h want=0", {pc, ir, acc, mdr}); end
    total++;
    if ({flag_z, flag_n, mem_busy, mem_done, mem_req, mem_we, bus_err} !== 7'b1000000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=1000000", {flag_z, flag_n, mem_busy, mem_done, mem_req, mem_we, bus_err});
    end
    reset = 0;
    inc_pc(3);
    mem_start = 1; step(); mem_start = 0;
    total++;
    if (mem_req !== 1'b1) begin bad++; $display("FAIL reset_prereq got=%b want=1", mem_req); end
    #2 reset = 1;
    #1;
    total++;
    if ({mem_req, mem_busy, pc, mdr, flag_z} !== {2'b00, 32'h0, 1'b1}) begin
      bad++; $display("FAIL reset_midreq req=%b busy=%b pc=%h mdr=%h z=%b want 0 0 0 0 1", mem_req, mem_busy, pc, mdr, flag_z);
    end
    @(posedge clk); #1;
    reset = 0; model_reset();
  endtask

  task automatic test_read_zero_wait();
    inc_pc(5);
    Asel = 0; mem_wr = 0; mem_start = 1; step(); mem_start = 0;
    total++;
    if ({mem_req, mem_we, mem_done, mem_addr} !== {3'b100, 12'h005}) begin
      bad++; $display("FAIL rd0_req req=%b we=%b done=%b addr=%h want 1 0 0 005", mem_req, mem_we, mem_done, mem_addr);
    end
    mem_ack = 1; mem_rdata = 16'hA123; step(); mem_ack = 0;
    total++;
    if ({mem_done, mem_req, mdr} !== {2'b10, 16'hA123}) begin
      bad++; $display("FAIL rd0_done done=%b req=%b mdr=%h want 1 0 a123", mem_done, mem_req, mdr);
    end
    step();
    total++;
    if ({mem_done, mem_busy, pc} !== {2'b00, 16'h0005}) begin
      bad++; $display("FAIL rd0_idle done=%b busy=%b pc=%h want 0 0 0005", mem_done, mem_busy, pc);
    end
  endtask

  task automatic test_read_wait();
    int stable = 0;
    int dones  = 0;
    logic [DW-1:0] d;
    d = DW'($urandom);
    Asel = 0; mem_start = 1; step(); mem_start = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req === 1'b1 && mem_addr === 12'h005 && mem_we === 1'b0) stable++;
      mem_start = (i == 1); mem_ack = (i == 3); mem_rdata = d;
      step();
      if (mem_done === 1'b1) dones++;
    end
    mem_start = 0; mem_ack = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_done === 1'b1) dones++;
    end
    total++;
    if (stable != 4) begin bad++; $display("FAIL rdw_stable got=%0d want=4", stable); end
    total++;
    if (dones != 1) begin bad++; $display("FAIL rdw_dones got=%0d want=1", dones); end
    total++;
    if (mdr !== d) begin bad++; $display("FAIL rdw_mdr got=%h want=%h", mdr, d); end
  endtask

  task automatic test_write();
    bus_read(16'h1234, 0); acc_from_mdr();
    bus_read(16'h2F0A, 1); IRen = 1; step(); IRen = 0;
    Asel = 1; mem_wr = 1; mem_start = 1; step(); mem_start = 0; mem_wr = 0; Asel = 0;
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 12'hF0A, 16'h1234}) begin
      bad++; $display("FAIL wr_bus req=%b we=%b addr=%h wdata=%h want 1 1 f0a 1234", mem_req, mem_we, mem_addr, mem_wdata);
    end
    Xsel = 1; M = 2'b10; ACCen = 1; step(); ACCen = 0; Xsel = 0;
    total++;
    if ({mem_wdata, acc} !== {16'h1234, 16'h1235}) begin
      bad++; $display("FAIL wr_hold wdata=%h acc=%h want 1234 1235", mem_wdata, acc);
    end
    mem_ack = 1; mem_rdata = 16'hBEEF; step(); mem_ack = 0;
    total++;
    if ({mem_done, mdr} !== {1'b1, 16'h2F0A}) begin
      bad++; $display("FAIL wr_done done=%b mdr=%h want 1 2f0a", mem_done, mdr);
    end
    step();
  endtask

  task automatic test_alu_flags();
    bus_read(16'hFFFF, 0); acc_from_mdr();
    Xsel = 1; M = 2'b10; ACCen = 1; step(); ACCen = 0;
    total++;
    if ({acc, flag_z, flag_n} !== {16'h0000, 2'b10}) begin
      bad++; $display("FAIL alu_inc_wrap acc=%h z=%b n=%b want 0000 1 0", acc, flag_z, flag_n);
    end
    bus_read(16'h0001, 0);
    Xsel = 1; Ysel = 1; M = 2'b11; ACCen = 1; step(); ACCen = 0; Xsel = 0; Ysel = 0;
    total++;
    if ({acc, flag_z, flag_n} !== {16'hFFFF, 2'b01}) begin
      bad++; $display("FAIL alu_sub_wrap acc=%h z=%b n=%b want ffff 0 1", acc, flag_z, flag_n);
    end
  endtask

  task automatic test_timeout();
    int hi = 0;
    logic [DW-1:0] keep;
    keep = m_mdr;
    Asel = 0; mem_wr = 0; mem_start = 1; step(); mem_start = 0;
`ifdef MU0_DP_TIMEOUT_EN
    for (int i = 0; i < TMO; i++) begin
      if (mem_req === 1'b1) hi++;
      step();
    end
    total++;
    if (hi != TMO) begin bad++; $display("FAIL tmo_req_cycles got=%0d want=%0d", hi, TMO); end
    total++;
    if ({mem_req, mem_done, bus_err, mdr} !== {3'b011, keep}) begin
      bad++; $display("FAIL tmo_abort req=%b done=%b err=%b mdr=%h want 0 1 1 %h", mem_req, mem_done, bus_err, mdr, keep);
    end
    step();
    total++;
    if ({mem_done, bus_err, mem_busy} !== 3'b000) begin
      bad++; $display("FAIL tmo_after done=%b err=%b busy=%b want 000", mem_done, bus_err, mem_busy);
    end
    mem_start = 1; step(); mem_start = 0;
    repeat (TMO - 1) step();
    mem_ack = 1; mem_rdata = 16'h5A5A; step(); mem_ack = 0;
    total++;
    if ({mem_done, bus_err, mdr} !== {2'b10, 16'h5A5A}) begin
      bad++; $display("FAIL tmo_ack_limit done=%b err=%b mdr=%h want 1 0 5a5a", mem_done, bus_err, mdr);
    end
    step();
`else
    for (int i = 0; i < 100; i++) begin
      if (mem_req === 1'b1 && mem_done === 1'b0) hi++;
      step();
    end
    total++;
    if (hi != 100) begin bad++; $display("FAIL notmo_hold got=%0d want=100", hi); end
    mem_ack = 1; mem_rdata = 16'h5A5A; step(); mem_ack = 0;
    total++;
    if ({mem_done, bus_err, mdr} !== {2'b10, 16'h5A5A}) begin
      bad++; $display("FAIL notmo_done done=%b err=%b mdr=%h want 1 0 5a5a", mem_done, bus_err, mdr);
    end
    step();
    total++;
    if (keep === 16'h5A5A && mdr !== 16'h5A5A) begin bad++; $display("FAIL notmo_mdr got=%h want=5a5a", mdr); end
`endif
  endtask

  task automatic test_random();
    logic [98:0] got, exp;
    int errs = 0;
    for (int i = 0; i < 500; i++) begin
      M = 2'($urandom); Xsel = 1'($urandom); Ysel = 1'($urandom); Asel = 1'($urandom);
      PCen = ($urandom_range(0, 3) == 0); IRen = ($urandom_range(0, 4) == 0);
      ACCen = ($urandom_range(0, 2) == 0);
      mem_start = ($urandom_range(0, 3) == 0); mem_wr = 1'($urandom);
      mem_ack = ($urandom_range(0, 9) < 3); mem_rdata = DW'($urandom);
      step();
      exp = {m_pc, m_ir, m_acc, m_mdr, m_z, m_n, m_phase == 1, m_phase == 2, m_phase != 0,
             (m_phase == 2) && m_err, (m_phase == 1) ? {m_we, m_addr, m_wdata} : 29'b0};
      got = {pc, ir, acc, mdr, flag_z, flag_n, mem_req, mem_done, mem_busy, bus_err,
             mem_req ? {mem_we, mem_addr, mem_wdata} : 29'b0};
      total++;
      if (got !== exp) begin
        bad++;
        if (errs < 10) $display("FAIL random cyc=%0d got=%h want=%h", i, got, exp);
        errs++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_read_wait();
    test_write();
    test_alu_flags();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
